seq_detector_prog: RTL and testbench

SEQ_DETECTOR_PROG -- requirements
Module: seq_detector_prog

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_match_counter.sv | 32 +++
 rtl/seq_detector_prog.sv | 121 ++++++++++++
 tb/tb_seq_detector_prog.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial sequence detector:
// overlap-mode encodings and the configuration length-width helper.
package seq_det_pkg;

    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

    // Number of bits needed to hold a pattern length in the range 0..max_len.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter. A synchronous clear takes priority over an
// increment in the same cycle, so a coincident event is dropped.
module seq_match_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_r;

    // Count register: async reset, clear first, then saturating increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial sequence detector. Accepted bits shift into a history
// register; a match is declared when enough bits have arrived and the low
// len bits of the history equal the low len bits of the pattern.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1011,
    parameter int                 RST_LEN     = 4,
    parameter logic               RST_OVERLAP = MODE_OVL
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic                         in_bit,
    input  logic                         cfg_we,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         clr_count,
    output logic                         detected,
    output logic [CNT_W-1:0]             match_count
);

    localparam int               LEN_W     = len_width(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] RST_LEN_L = (RST_LEN > MAX_LEN) ? MAX_LEN_L : LEN_W'(RST_LEN);

    // Configuration registers
    logic [MAX_LEN-1:0] pattern_r;
    logic [LEN_W-1:0]   len_r;
    logic               overlap_r;

    // Datapath registers
    logic [MAX_LEN-1:0] hist_r;
    logic [LEN_W-1:0]   fill_r;
    logic               detected_r;

    // Next-state combinational values
    logic               accept_s;
    logic [MAX_LEN-1:0] hist_shift_s;
    logic [LEN_W-1:0]   fill_inc_s;
    logic [LEN_W-1:0]   fill_next_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               match_s;
    logic [LEN_W-1:0]   cfg_len_clamped_s;

    // A configuration write owns the cycle, so the data bit is not taken.
    assign accept_s = in_valid & ~cfg_we;

    // Compute the post-shift history and fill, and evaluate the comparator on them.
    always_comb begin
        hist_shift_s = (hist_r << 1) | {{(MAX_LEN-1){1'b0}}, in_bit};

        if (fill_r == MAX_LEN_L) begin
            fill_inc_s = fill_r;
        end else begin
            fill_inc_s = fill_r + LEN_W'(1);
        end

        mask_s = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (i < int'(len_r));
        end

        // len of zero would give an empty mask that trivially compares equal.
        match_s = accept_s && (len_r != '0) && (fill_inc_s >= len_r)
                  && ((hist_shift_s & mask_s) == (pattern_r & mask_s));

        if (match_s && (overlap_r == MODE_NONOVL)) begin
            fill_next_s = '0;
        end else begin
            fill_next_s = fill_inc_s;
        end

        if (cfg_len > MAX_LEN_L) begin
            cfg_len_clamped_s = MAX_LEN_L;
        end else begin
            cfg_len_clamped_s = cfg_len;
        end
    end

    // Configuration, history, fill and registered match pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_r  <= RST_PATTERN;
            len_r      <= RST_LEN_L;
            overlap_r  <= RST_OVERLAP;
            hist_r     <= '0;
            fill_r     <= '0;
            detected_r <= 1'b0;
        end else if (cfg_we) begin
            pattern_r  <= cfg_pattern;
            len_r      <= cfg_len_clamped_s;
            overlap_r  <= cfg_overlap;
            hist_r     <= '0;
            fill_r     <= '0;
            detected_r <= 1'b0;
        end else if (accept_s) begin
            hist_r     <= hist_shift_s;
            fill_r     <= fill_next_s;
            detected_r <= match_s;
        end else begin
            detected_r <= 1'b0;
        end
    end

    assign detected = detected_r;

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (match_s),
        .clr   (clr_count),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog. The driver pushes the expected
// detected/match_count for the cycle following each edge; a monitor pops and
// compares on the falling edge. A 2-bit counter is used so saturation is
// reachable with a handful of matches.
module tb_seq_detector_prog;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_bit;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       clr_count;
    logic       detected;
    logic [1:0] match_count;

    typedef struct {
        logic       det;
        logic [1:0] cnt;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   exp_count = 0;

    seq_detector_prog #(
        .MAX_LEN     (8),
        .CNT_W       (2),
        .RST_PATTERN (8'b0000_1011),
        .RST_LEN     (4),
        .RST_OVERLAP (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .clr_count   (clr_count),
        .detected    (detected),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    // Monitor: compare DUT outputs against the oldest pending expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (detected === mon_e.det) n_pass++;
            else $display("FAIL %s detected: got %b expected %b", mon_e.name, detected, mon_e.det);
            n_checks++;
            if (match_count === mon_e.cnt) n_pass++;
            else $display("FAIL %s match_count: got %0d expected %0d", mon_e.name, match_count, mon_e.cnt);
        end
    end

    // One clock edge with the given inputs, then queue the expected outputs.
    task automatic step(input logic v, input logic b, input logic we, input logic clr,
                        input logic edet, input int ecnt, input string nm);
        in_valid  = v;
        in_bit    = b;
        cfg_we    = we;
        clr_count = clr;
        @(posedge clk);
        exp_q.push_back('{det: edet, cnt: 2'(ecnt), name: nm});
        #1;
        in_valid  = 1'b0;
        cfg_we    = 1'b0;
        clr_count = 1'b0;
    endtask

    // Feed n bits MSB first; dets holds the hand-computed pulse per bit.
    task automatic stream(input logic [15:0] bits, input logic [15:0] dets, input int n,
                          input logic bubble, input string nm);
        logic d;
        for (int i = 0; i < n; i++) begin
            d = dets[n-1-i];
            if (d && exp_count < 3) exp_count++;
            step(1'b1, bits[n-1-i], 1'b0, 1'b0, d, exp_count, nm);
            if (bubble) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_count, {nm, "_bubble"});
        end
    endtask

    task automatic do_clear();
        exp_count = 0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "clr");
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                          input string nm);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        // in_valid=1 with a 1 on the data line: must be ignored during the write.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, exp_count, nm);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        exp_count = 0;
        exp_q.push_back('{det: 1'b0, cnt: 2'd0, name: "reset"});
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        cfg_we      = 1'b0;
        cfg_pattern = 8'h00;
        cfg_len     = 4'd0;
        cfg_overlap = 1'b0;
        clr_count   = 1'b0;
        #2;
        do_reset();

        // Defaults: overlapping 1011
        stream(16'b1011011, 16'b0001001, 7, 1'b0, "ovl_default");
        // Config write leaves the count alone
        do_cfg(8'b0000_1011, 4'd4, 1'b0, "cfg_nonovl");
        do_clear();
        stream(16'b1011011, 16'b0001000, 7, 1'b0, "nonovl");

        // Length 3, pattern 110, bubbles between bits
        do_cfg(8'b0000_0110, 4'd3, 1'b1, "cfg_len3");
        do_clear();
        stream(16'b110110, 16'b001001, 6, 1'b1, "len3_bubbles");
        do_clear();

        // Five matches saturate the 2-bit counter at 3
        stream(16'b110110110110110, 16'b001001001001001, 15, 1'b0, "saturate");
        // Clear coincident with a match: count 0, pulse still seen
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, "pre_clr_match");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, "pre_clr_match");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, "clr_vs_match");
        exp_count = 0;

        // Partial match discarded by reset; configuration returns to 1011
        stream(16'b101, 16'b000, 3, 1'b0, "pre_reset");
        do_reset();
        stream(16'b1011, 16'b0001, 4, 1'b0, "after_reset");

        // Zero length disables detection
        do_cfg(8'h00, 4'd0, 1'b1, "cfg_len0");
        stream(16'b00000000, 16'b00000000, 8, 1'b0, "len0");

        // Oversized length clamps to the full 8 bits
        do_cfg(8'b1010_0110, 4'd13, 1'b1, "cfg_len13");
        stream(16'b10100110, 16'b00000001, 8, 1'b0, "len_clamp");
        stream(16'b10100110, 16'b00000001, 8, 1'b0, "len_clamp2");

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
